mmsa_tx: RTL and testbench
==========================

MMSA_TX -- requirements
Module: mmsa_tx

Interface
REQ-001 Parameter DATA_W, default 16: bit width of one matrix element.
REQ-002 Parameter IDX_W, default 4: bit width of one matrix index.
REQ-003 Parameter NUM_MAT, default 32: matrices per load (16 input, then 16 weight).
REQ-004 Parameter NUM_ROUNDS, default 16: index pairs sent per load.
REQ-005 Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load session.
- cfg_size  in  2  matrix size: 00=2x2, 01=4x4, 10=8x8.
- elem_valid  in  1  host element valid.
- elem_data  in  DATA_W  host element, signed.
- elem_ready  out  1  element accepted when valid&ready.
- idx_valid  in  1  host index pair valid.
- idx_i  in  IDX_W  input-matrix index.
- idx_w  in  IDX_W  weight-matrix index.
- idx_ready  out  1  index pair accepted when valid&ready.
- core_out_valid  in  1  out_valid returned from the core.
- in_valid, matrix  out  1 each  serial element stream to core.
- matrix_size  out  2  size to core.
- in_valid2, i_mat_idx, w_mat_idx  out  1 each  serial index stream to core.
- busy  out  1  session in progress.
- err_underrun  out  1  sticky underrun flag.

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, IDX_WAIT, IDX_SEND, RSP_WAIT.
REQ-007 In IDLE, start=1 with cfg_size!=11 SHALL latch cfg_size and enter LOAD; start with cfg_size=11 SHALL be ignored.
REQ-008 start while busy=1 SHALL be ignored.
REQ-009 LOAD SHALL serialize NUM_MAT*n*n elements (n=2/4/8), MSB first, one bit per cycle on matrix with in_valid=1.
REQ-010 A one-entry prefetch register SHALL let elem_ready assert during the final bit of the current element, so valid input gives a gap-free in_valid.
REQ-011 If no element is available when a new element is due, in_valid and matrix SHALL be 0 for each bubble cycle, and serialization SHALL resume on the next accepted element.
REQ-012 matrix_size SHALL carry the latched size only on the first in_valid cycle of the session and SHALL be 0 otherwise.
REQ-013 After the last bit of the last element, the FSM SHALL enter IDX_WAIT on the next cycle.
REQ-014 idx_ready SHALL be 1 only in IDX_WAIT.
REQ-015 On acceptance, IDX_SEND SHALL drive in_valid2=1 for IDX_W cycles, with idx_i and idx_w sent MSB first on i_mat_idx and w_mat_idx in parallel.
REQ-016 RSP_WAIT SHALL hold until a falling edge of core_out_valid, then increment the round count.
REQ-017 After NUM_ROUNDS rounds the FSM SHALL return to IDLE; otherwise it SHALL return to IDX_WAIT.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 All core-side outputs SHALL be registered and SHALL be 0 whenever not actively signalling.
REQ-020 The element counter SHALL be wide enough for 32*64 without wrap-around.

Reset
REQ-021 rst_n=0 SHALL asynchronously force IDLE, clear all counters, the prefetch register and err_underrun, and drive every output to 0, including mid-session.
REQ-022 Operation SHALL resume on the first clk edge after rst_n deasserts.

Configuration
REQ-023 With MMSA_TX_UNDERRUN_CHK_EN defined, err_underrun SHALL set on any LOAD bubble cycle and hold until reset.
REQ-024 Without MMSA_TX_UNDERRUN_CHK_EN, err_underrun SHALL be tied 0 and no check logic SHALL be built.

Structure
REQ-025 Package mmsa_pkg SHALL hold the state enum, the size codes, and a size-to-element-count function.
REQ-026 Sub-module mmsa_piso (a parameterized load/shift register with done pulse) SHALL be used for both the element shifter and the index shifter.

Verification
REQ-027 Reset: rst_n=0 with no clk edge -> all outputs 0 and busy=0.
REQ-028 Load, cfg_size=00 with elements streamed back-to-back -> exactly 32*4*16=2048 contiguous in_valid cycles, matrix_size=00 on the first cycle only, and first element 16'h8001 sent as 1,0...0,1.
REQ-029 Load, cfg_size=10 with elem_valid low for 3 cycles mid-stream -> 3 in_valid=0 bubbles and an unchanged bit sequence; err_underrun=1 only with the macro defined.
REQ-030 Index round, idx_i=4'hA and idx_w=4'h3 -> in_valid2 high for 4 cycles, i_mat_idx=1,0,1,0 and w_mat_idx=0,0,1,1; no further idx_ready until core_out_valid falls.
REQ-031 Session end: 16 rounds complete -> busy falls one cycle after the 16th core_out_valid fall; start with cfg_size=11 -> stays IDLE.
REQ-032 Reset mid-LOAD at element 100 -> outputs 0 immediately; a new start reloads from element 0.

Source files
------------

// File: rtl/mmsa_pkg.sv
// Shared definitions for the mmsa_tx matrix/index serializer: FSM state codes,
// matrix-size codes and the size-to-element-count helper.
package mmsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_IDX_WAIT = 3'd2,
    ST_IDX_SEND = 3'd3,
    ST_RSP_WAIT = 3'd4
  } mmsa_state_e;

  localparam logic [1:0] SZ_2X2  = 2'b00;
  localparam logic [1:0] SZ_4X4  = 2'b01;
  localparam logic [1:0] SZ_8X8  = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int MAX_MAT_ELEMS = 64;

  // Elements in one n x n matrix for a size code; reserved code yields 0.
  function automatic int unsigned mat_elems(input logic [1:0] sz);
    case (sz)
      SZ_2X2:  return 4;
      SZ_4X4:  return 16;
      SZ_8X8:  return 64;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/mmsa_tx_if.sv
// Host/core signal bundle for mmsa_tx. The master side is the host plus the
// core's out_valid return; the slave side is the serializer itself.
interface mmsa_tx_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic              start;
  logic [1:0]        cfg_size;
  logic              elem_valid;
  logic [DATA_W-1:0] elem_data;
  logic              elem_ready;
  logic              idx_valid;
  logic [IDX_W-1:0]  idx_i;
  logic [IDX_W-1:0]  idx_w;
  logic              idx_ready;
  logic              core_out_valid;
  logic              in_valid;
  logic              matrix;
  logic [1:0]        matrix_size;
  logic              in_valid2;
  logic              i_mat_idx;
  logic              w_mat_idx;
  logic              busy;
  logic              err_underrun;

  modport master (
    output start, cfg_size, elem_valid, elem_data, idx_valid, idx_i, idx_w,
           core_out_valid,
    input  elem_ready, idx_ready, in_valid, matrix, matrix_size, in_valid2,
           i_mat_idx, w_mat_idx, busy, err_underrun
  );

  modport slave (
    input  start, cfg_size, elem_valid, elem_data, idx_valid, idx_i, idx_w,
           core_out_valid,
    output elem_ready, idx_ready, in_valid, matrix, matrix_size, in_valid2,
           i_mat_idx, w_mat_idx, busy, err_underrun
  );
endinterface

// File: rtl/mmsa_piso.sv
// Load/shift register: emits W bits MSB first, one per cycle, with a done
// pulse on the final bit. Shifting in zeros leaves sout low once idle.
module mmsa_piso #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         sout,
  output logic         active,
  output logic         done
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;

  assign sout = sr[W-1];
  assign done = active && (cnt == CW'(W - 1));

  // A load on the done cycle restarts immediately, giving gap-free output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      sr     <= din;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      sr  <= {sr[W-2:0], 1'b0};
      cnt <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end
endmodule

// File: rtl/mmsa_tx.sv
// Serializes a session of host matrix elements then index pairs to the core.
// Optional underrun flag built only with MMSA_TX_UNDERRUN_CHK_EN defined.
module mmsa_tx
  import mmsa_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IDX_W      = 4,
  parameter int NUM_MAT    = 32,
  parameter int NUM_ROUNDS = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mmsa_tx_if.slave  bus
);
  localparam int CNT_W = $clog2(NUM_MAT * MAX_MAT_ELEMS + 1);
  localparam int RND_W = $clog2(NUM_ROUNDS + 1);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] LOAD     = ST_LOAD;
  localparam logic [2:0] IDX_WAIT = ST_IDX_WAIT;
  localparam logic [2:0] IDX_SEND = ST_IDX_SEND;
  localparam logic [2:0] RSP_WAIT = ST_RSP_WAIT;

  logic [2:0]        state;
  logic [1:0]        size_q;
  logic [1:0]        msz_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  total;
  logic              pf_vld;
  logic [DATA_W-1:0] pf_data;
  logic              first_q;
  logic [RND_W-1:0]  rnd_cnt;
  logic              cov_q;

  logic              sh_bit, sh_active, sh_done;
  logic              pop, elem_ready, elem_acc, start_ok, load_end, idx_acc, idx_end;

  logic [1:0][IDX_W-1:0] idx_pair;
  logic [1:0]            idx_bit, idx_act, idx_done;

  assign total    = CNT_W'(NUM_MAT * mat_elems(size_q));
  assign start_ok = (state == IDLE) && bus.start && (bus.cfg_size != SZ_RSVD);
  // Prefetch hands over while the shifter is idle or on its last bit.
  assign pop        = (state == LOAD) && pf_vld && (!sh_active || sh_done);
  assign elem_ready = (state == LOAD) && (acc_cnt != total) && (!pf_vld || pop);
  assign elem_acc   = elem_ready && bus.elem_valid;
  assign load_end   = (state == LOAD) && sh_done && !pf_vld && (acc_cnt == total);
  assign idx_acc    = (state == IDX_WAIT) && bus.idx_valid;
  assign idx_end    = &idx_done;
  assign idx_pair   = {bus.idx_w, bus.idx_i};

  mmsa_piso #(.W(DATA_W)) u_elem (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pop),
    .din    (pf_data),
    .sout   (sh_bit),
    .active (sh_active),
    .done   (sh_done)
  );

  for (genvar g = 0; g < 2; g++) begin : g_idx
    mmsa_piso #(.W(IDX_W)) u_piso (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (idx_acc),
      .din    (idx_pair[g]),
      .sout   (idx_bit[g]),
      .active (idx_act[g]),
      .done   (idx_done[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      size_q  <= '0;
      msz_q   <= '0;
      acc_cnt <= '0;
      pf_vld  <= 1'b0;
      pf_data <= '0;
      first_q <= 1'b0;
      rnd_cnt <= '0;
      cov_q   <= 1'b0;
    end else begin
      cov_q <= bus.core_out_valid;
      // Size is announced only alongside the session's first serial bit.
      msz_q <= (pop && first_q) ? size_q : 2'b00;
      if (elem_acc) begin
        pf_vld  <= 1'b1;
        pf_data <= bus.elem_data;
        acc_cnt <= acc_cnt + 1'b1;
      end else if (pop) begin
        pf_vld <= 1'b0;
      end
      if (pop) first_q <= 1'b0;

      case (state)
        IDLE: if (start_ok) begin
          state   <= LOAD;
          size_q  <= bus.cfg_size;
          acc_cnt <= '0;
          first_q <= 1'b1;
          rnd_cnt <= '0;
        end
        LOAD:     if (load_end) state <= IDX_WAIT;
        IDX_WAIT: if (idx_acc)  state <= IDX_SEND;
        IDX_SEND: if (idx_end)  state <= RSP_WAIT;
        RSP_WAIT: if (cov_q && !bus.core_out_valid) begin
          if (rnd_cnt == RND_W'(NUM_ROUNDS - 1)) begin
            state   <= IDLE;
            rnd_cnt <= '0;
          end else begin
            state   <= IDX_WAIT;
            rnd_cnt <= rnd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MMSA_TX_UNDERRUN_CHK_EN
  logic err_q;
  // Bubble: shifter idle in LOAD after the first element has gone out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if ((state == LOAD) && !sh_active && !first_q) err_q <= 1'b1;
  end
  assign bus.err_underrun = err_q;
`else
  assign bus.err_underrun = 1'b0;
`endif

  assign bus.elem_ready  = elem_ready;
  assign bus.idx_ready   = (state == IDX_WAIT);
  assign bus.in_valid    = sh_active;
  assign bus.matrix      = sh_bit;
  assign bus.matrix_size = msz_q;
  assign bus.in_valid2   = |idx_act;
  assign bus.i_mat_idx   = idx_bit[0];
  assign bus.w_mat_idx   = idx_bit[1];
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mmsa_tx.sv
// Directed bench for mmsa_tx: reset, loads (clean and starved), index rounds,
// session end, ignored starts and mid-load reset.
module tb_mmsa_tx;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

`ifdef MMSA_TX_UNDERRUN_CHK_EN
  localparam bit UND_EN = 1'b1;
`else
  localparam bit UND_EN = 1'b0;
`endif

  mmsa_tx_if #(.DATA_W(16), .IDX_W(4)) bus ();

  mmsa_tx #(.DATA_W(16), .IDX_W(4), .NUM_MAT(32), .NUM_ROUNDS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          ld_bits, ld_bubbles, ld_bit_errs, ld_first_err, ld_msz_other, ld_quiet_errs;
  logic [1:0]  ld_msz_first;
  logic [15:0] ld_first16;
  logic        ld_idx_next, ld_done;

  logic [3:0]  rd_gi, rd_gw;
  int          rd_v2, rd_early;
  logic        rd_busy_fall, rd_busy_after, rd_ready_after;

  function automatic logic [15:0] elem_val(input int k);
    if (k == 0) return 16'h8001;
    return 16'(k * 40503 + 12345);
  endfunction

  function automatic logic [10:0] all_outs();
    return {bus.elem_ready, bus.idx_ready, bus.in_valid, bus.matrix, bus.matrix_size,
            bus.in_valid2, bus.i_mat_idx, bus.w_mat_idx, bus.busy, bus.err_underrun};
  endfunction

  // Starts a session and feeds elements; samples and drives at negedges.
  task automatic do_load(input logic [1:0] sz, input int stall_at, input int abort_at);
    int total, k, stall, cyc;
    logic [15:0] ev;
    total = 32 * ((sz == 2'b00) ? 4 : (sz == 2'b01) ? 16 : 64);
    k = 0; stall = 0; cyc = 0;
    ld_bits = 0; ld_bubbles = 0; ld_bit_errs = 0; ld_first_err = -1; ld_msz_other = 0;
    ld_quiet_errs = 0; ld_msz_first = 2'b11; ld_first16 = '0; ld_idx_next = 1'b0; ld_done = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.cfg_size = sz;
    @(negedge clk); bus.start = 1'b0;
    while (cyc < total * 16 + 300) begin
      if (bus.in_valid === 1'b1) begin
        ev = elem_val(ld_bits / 16);
        if (bus.matrix !== ev[15 - ld_bits % 16]) begin
          if (ld_bit_errs == 0) ld_first_err = ld_bits;
          ld_bit_errs++;
        end
        if (ld_bits == 0) ld_msz_first = bus.matrix_size;
        else if (bus.matrix_size !== 2'b00) ld_msz_other++;
        if (ld_bits < 16) ld_first16 = {ld_first16[14:0], bus.matrix};
        ld_bits++;
      end else begin
        if (bus.matrix !== 1'b0 || bus.matrix_size !== 2'b00) ld_quiet_errs++;
        if (ld_bits == total * 16) begin
          ld_idx_next = bus.idx_ready;
          ld_done = 1'b1;
          break;
        end
        if (ld_bits > 0) begin
          ld_bubbles++;
          if (stall == 1) stall = 3;
        end
      end
      if (abort_at >= 0 && k == abort_at) begin
        ld_done = 1'b1;
        break;
      end
      if (stall_at >= 0 && k == stall_at && stall == 0) stall = 1;
      bus.elem_valid = (k < total) && (stall != 1) && (stall != 3);
      bus.elem_data  = elem_val(k);
      if (bus.elem_valid && bus.elem_ready) k++;
      if (stall == 3) stall = 2;
      cyc++;
      @(negedge clk);
    end
    bus.elem_valid = 1'b0;
  endtask

  // One index round; returns at the negedge after the core_out_valid fall.
  task automatic do_round(input logic [3:0] ii, input logic [3:0] ww);
    rd_gi = '0; rd_gw = '0; rd_v2 = 0; rd_early = 0;
    bus.idx_valid = 1'b1; bus.idx_i = ii; bus.idx_w = ww;
    @(negedge clk); bus.idx_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bus.in_valid2 === 1'b1) begin
        rd_v2++;
        rd_gi = {rd_gi[2:0], bus.i_mat_idx};
        rd_gw = {rd_gw[2:0], bus.w_mat_idx};
      end
      if (bus.idx_ready !== 1'b0) rd_early++;
      @(negedge clk);
    end
    bus.core_out_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (bus.idx_ready !== 1'b0) rd_early++;
      @(negedge clk);
    end
    bus.core_out_valid = 1'b0;
    if (bus.idx_ready !== 1'b0) rd_early++;
    rd_busy_fall = bus.busy;
    @(negedge clk);
    rd_ready_after = bus.idx_ready;
    rd_busy_after  = bus.busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start = 0; bus.cfg_size = 0; bus.elem_valid = 0; bus.elem_data = 0;
    bus.idx_valid = 0; bus.idx_i = 0; bus.idx_w = 0; bus.core_out_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (all_outs() !== 11'd0) begin errors++; $display("FAIL reset_outs: got %b expected 0", all_outs()); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_load_2x2();
    do_load(2'b00, -1, -1);
    checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL load00_timeout: load did not complete"); end
    checks++; if (ld_bits != 2048) begin errors++; $display("FAIL load00_bits: got %0d expected 2048", ld_bits); end
    checks++; if (ld_bubbles != 0) begin errors++; $display("FAIL load00_gaps: got %0d expected 0", ld_bubbles); end
    checks++; if (ld_first16 !== 16'h8001) begin errors++; $display("FAIL load00_first_elem: got %h expected 8001", ld_first16); end
    checks++; if (ld_bit_errs != 0) begin errors++; $display("FAIL load00_stream: %0d bad bits, first at %0d, expected 0", ld_bit_errs, ld_first_err); end
    checks++; if (ld_msz_first !== 2'b00 || ld_msz_other != 0) begin errors++; $display("FAIL load00_msize: first %b others %0d expected 00/0", ld_msz_first, ld_msz_other); end
    checks++; if (ld_quiet_errs != 0) begin errors++; $display("FAIL load00_quiet: got %0d expected 0", ld_quiet_errs); end
    checks++; if (ld_idx_next !== 1'b1) begin errors++; $display("FAIL load00_idx_wait: got %b expected 1", ld_idx_next); end
    checks++; if (bus.err_underrun !== 1'b0) begin errors++; $display("FAIL load00_err: got %b expected 0", bus.err_underrun); end
  endtask

  task automatic test_busy_start();
    bus.start = 1'b1; bus.cfg_size = 2'b10;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.idx_ready !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL busy_start: idx_ready %b busy %b expected 1/1", bus.idx_ready, bus.busy); end
    checks++; if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL busy_start_reload: in_valid %b expected 0", bus.in_valid); end
  endtask

  task automatic test_index_round();
    do_round(4'hA, 4'h3);
    checks++; if (rd_v2 != 4) begin errors++; $display("FAIL idx_len: got %0d expected 4", rd_v2); end
    checks++; if (rd_gi !== 4'hA) begin errors++; $display("FAIL idx_i_bits: got %h expected a", rd_gi); end
    checks++; if (rd_gw !== 4'h3) begin errors++; $display("FAIL idx_w_bits: got %h expected 3", rd_gw); end
    checks++; if (rd_early != 0) begin errors++; $display("FAIL idx_early_ready: got %0d expected 0", rd_early); end
    checks++; if (rd_ready_after !== 1'b1) begin errors++; $display("FAIL idx_next_round: got %b expected 1", rd_ready_after); end
  endtask

  task automatic test_session_end();
    int bad;
    bad = 0;
    for (int r = 2; r <= 15; r++) begin
      do_round(4'(r), ~4'(r));
      if (rd_v2 != 4 || rd_gi !== 4'(r) || rd_gw !== ~4'(r) || rd_early != 0 || rd_ready_after !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rounds_2_15: %0d bad rounds expected 0", bad); end
    do_round(4'hF, 4'h0);
    checks++; if (rd_busy_fall !== 1'b1) begin errors++; $display("FAIL end_busy_before: got %b expected 1", rd_busy_fall); end
    checks++; if (rd_busy_after !== 1'b0 || rd_ready_after !== 1'b0) begin errors++; $display("FAIL end_busy_after: busy %b idx_ready %b expected 0/0", rd_busy_after, rd_ready_after); end
  endtask

  task automatic test_start_ignored();
    bus.start = 1'b1; bus.cfg_size = 2'b11;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.elem_ready !== 1'b0) begin errors++; $display("FAIL start_rsvd: busy %b elem_ready %b expected 0/0", bus.busy, bus.elem_ready); end
  endtask

  task automatic test_underrun();
    do_load(2'b10, 200, -1);
    checks++; if (ld_done !== 1'b1 || ld_bits != 32768) begin errors++; $display("FAIL load10_bits: got %0d expected 32768", ld_bits); end
    checks++; if (ld_bubbles != 3) begin errors++; $display("FAIL load10_bubbles: got %0d expected 3", ld_bubbles); end
    checks++; if (ld_bit_errs != 0) begin errors++; $display("FAIL load10_stream: %0d bad bits, first at %0d, expected 0", ld_bit_errs, ld_first_err); end
    checks++; if (ld_msz_first !== 2'b10 || ld_msz_other != 0) begin errors++; $display("FAIL load10_msize: first %b others %0d expected 10/0", ld_msz_first, ld_msz_other); end
    checks++; if (ld_quiet_errs != 0) begin errors++; $display("FAIL load10_quiet: got %0d expected 0", ld_quiet_errs); end
    checks++; if (bus.err_underrun !== UND_EN) begin errors++; $display("FAIL load10_err: got %b expected %b", bus.err_underrun, UND_EN); end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_load(2'b01, -1, 100);
    checks++; if (bus.busy !== 1'b1 || ld_bits < 1500) begin errors++; $display("FAIL mid_load_active: busy %b bits %0d expected 1/>=1500", bus.busy, ld_bits); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (all_outs() !== 11'd0) begin errors++; $display("FAIL mid_reset_outs: got %b expected 0", all_outs()); end
    @(negedge clk); rst_n = 1'b1;
    do_load(2'b01, -1, -1);
    checks++; if (ld_done !== 1'b1 || ld_bits != 8192) begin errors++; $display("FAIL reload_bits: got %0d expected 8192", ld_bits); end
    checks++; if (ld_first16 !== 16'h8001) begin errors++; $display("FAIL reload_first_elem: got %h expected 8001", ld_first16); end
    checks++; if (ld_bit_errs != 0 || ld_bubbles != 0) begin errors++; $display("FAIL reload_stream: %0d bad bits %0d bubbles expected 0/0", ld_bit_errs, ld_bubbles); end
    checks++; if (bus.err_underrun !== 1'b0) begin errors++; $display("FAIL reload_err: got %b expected 0", bus.err_underrun); end
  endtask

  initial begin
    test_reset();
    test_load_2x2();
    test_busy_start();
    test_index_round();
    test_session_end();
    test_start_ignored();
    test_underrun();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
